servo_dispense_driver: RTL and testbench
========================================

Name: servo_dispense_driver

Overview:
Downstream actuator stage for the dispenser control path. Consumes single-cycle dispense requests (scheduled dose or manual override) and drives a hobby-servo PWM output on a GPIO pin: rotate to open, hold for a fixed number of seconds, rotate back, report completion. Requests that arrive while a dose is in progress are queued in a small saturating counter, so no dose is lost up to MAX_PENDING.

Parameters:
PWM_PERIOD, 1000000, clock cycles per servo frame (20 ms at 50 MHz).
PULSE_CLOSED, 50000, high time in cycles for the closed position (1 ms).
PULSE_OPEN, 100000, high time in cycles for the open position (2 ms).
HOLD_SECONDS, 2, number of second_pulse events spent in OPEN.
SETTLE_FRAMES, 25, full PWM frames spent in CLOSE before completion.
MAX_PENDING, 3, queue depth for outstanding requests (1..7).

Ports:
clock  input  1  system clock (CLOCK_50 at top level).
resetn  input  1  synchronous, active-low reset (KEY[0] at top level).
second_pulse  input  1  one-cycle 1 Hz tick from the seconds counter.
enable  input  1  when 0, new requests are ignored; a dose in progress still completes.
dispense_req  input  1  one-cycle scheduled-dose request.
override_req  input  1  one-cycle manual-override request.
servo_pwm  output  1  servo control signal to GPIO.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when a dose completes.
req_dropped  output  1  one-cycle pulse when a request is lost to a full queue.
pending  output  3  number of queued requests not yet started.
dose_count  output  8  completed doses, saturating at 255.

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; servo_pwm, busy, done and req_dropped are 0; pending and dose_count are 0; PWM counter is 0; latched width is PULSE_CLOSED. Reset takes effect mid-dose with no completion pulse.
- Request accept: req = enable & (dispense_req | override_req). Both inputs high in the same cycle count as one request.
- Queue rules:
  - If req and pending < MAX_PENDING, pending increments.
  - If req and pending == MAX_PENDING, pending is unchanged and req_dropped pulses the next cycle.
  - If a request is accepted and a dose is dequeued in the same cycle, pending is unchanged.
- PWM generator:
  - Counter runs 0..PWM_PERIOD-1 and wraps.
  - servo_pwm is registered and high while counter < latched width, so each frame is exactly width cycles high.
  - The latched width loads the FSM target only when the counter is PWM_PERIOD-1, so frames are never truncated.
  - The PWM runs continuously, including in IDLE (holds the closed position).
- FSM target width: PULSE_OPEN in OPEN; PULSE_CLOSED in all other states.
- IDLE: if pending > 0, decrement pending and go to OPEN on the next cycle. busy rises in the same cycle the state becomes OPEN.
- OPEN: count second_pulse events. On the HOLD_SECONDS-th event, go to CLOSE. A second_pulse in the entry cycle counts. The hold is therefore HOLD_SECONDS-1 to HOLD_SECONDS seconds.
- CLOSE: count PWM frame wraps (counter == PWM_PERIOD-1). On the SETTLE_FRAMES-th wrap, go to DONE.
- DONE: lasts one cycle. done=1; dose_count increments unless it is 255. Next state is IDLE, which may immediately dequeue the next request.
- enable falling during OPEN or CLOSE has no effect on the current dose. Queued requests remain queued and are still served.
- Internal counters are sized from the parameters with no overflow. Counting uses equality compares.

Test Plan:
Test parameters for all scenarios: PWM_PERIOD=100, PULSE_CLOSED=5, PULSE_OPEN=10, HOLD_SECONDS=2, SETTLE_FRAMES=1, MAX_PENDING=3; second_pulse every 300 cycles.
1. Reset, then idle for 300 cycles -> servo_pwm is high for exactly 5 of every 100 cycles; busy=0, pending=0, dose_count=0.
2. Single dispense_req -> busy rises within 2 cycles. First full frame after the width latch has 10 high cycles. After the 2nd second_pulse, frames return to 5 high cycles. One done pulse after 1 frame wrap; dose_count=1; busy=0.
3. Five override_req pulses, 10 cycles apart, while a dose is active -> pending saturates at 3 and req_dropped pulses twice. Doses then run back-to-back: done pulses 4 times in total and dose_count=4.
4. dispense_req and override_req high in the same cycle -> treated as one request; dose_count=1 at the end.
5. enable=0 with dispense_req pulsed -> no state change and pending stays 0. Then enable=1 mid-dose and drop enable during OPEN -> the dose still completes and done pulses.
6. resetn=0 for 1 cycle during OPEN with pending=2 -> state IDLE, pending=0, no done pulse, PWM resumes 5-cycle width from counter 0.

Source files
------------

// File: rtl/servo_dispense_driver.sv
// Servo actuator stage: queues single-cycle dispense requests and runs each dose as
// open -> hold -> close -> settle on a continuously running hobby-servo PWM output.
module servo_dispense_driver #(
    parameter int PWM_PERIOD    = 1000000,
    parameter int PULSE_CLOSED  = 50000,
    parameter int PULSE_OPEN    = 100000,
    parameter int HOLD_SECONDS  = 2,
    parameter int SETTLE_FRAMES = 25,
    parameter int MAX_PENDING   = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       second_pulse,
    input  logic       enable,
    input  logic       dispense_req,
    input  logic       override_req,
    output logic       servo_pwm,
    output logic       busy,
    output logic       done,
    output logic       req_dropped,
    output logic [2:0] pending,
    output logic [7:0] dose_count
);

    localparam int CW = $clog2(PWM_PERIOD + 1);
    localparam int HW = $clog2(HOLD_SECONDS + 1);
    localparam int SW = $clog2(SETTLE_FRAMES + 1);

    localparam logic [CW-1:0] LAST_TICK   = CW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0] W_OPEN      = CW'(PULSE_OPEN);
    localparam logic [CW-1:0] W_CLOSED    = CW'(PULSE_CLOSED);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_SECONDS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_FRAMES - 1);
    localparam logic [2:0]    PEND_MAX    = 3'(MAX_PENDING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_CLOSE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   pwm_cnt;
    logic [CW-1:0]   width_q;
    logic [CW-1:0]   target_width;
    logic [HW-1:0]   hold_cnt;
    logic [SW-1:0]   settle_cnt;
    logic            frame_wrap;
    logic            hold_last;
    logic            settle_last;
    logic            dequeue;
    logic            req;
    logic            accept;
    logic            drop;

    assign frame_wrap  = (pwm_cnt == LAST_TICK);
    assign hold_last   = second_pulse && (hold_cnt == HOLD_LAST);
    assign settle_last = frame_wrap && (settle_cnt == SETTLE_LAST);

    assign req    = enable & (dispense_req | override_req);
    assign accept = req && (pending != PEND_MAX);
    assign drop   = req && (pending == PEND_MAX);

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    // Width only changes at the frame boundary, so every frame is a whole pulse.
    // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pwm_cnt   <= '0;
            width_q   <= W_CLOSED;
            servo_pwm <= 1'b0;
        end else begin
            servo_pwm <= (pwm_cnt < width_q);
            if (frame_wrap) begin
                pwm_cnt <= '0;
                width_q <= target_width;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        target_width = W_CLOSED;
        dequeue      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending != '0) begin
                    dequeue = 1'b1;
                    state_d = S_OPEN;
                end
            end
            S_OPEN: begin
                target_width = W_OPEN;
                if (hold_last) state_d = S_CLOSE;
            end
            S_CLOSE: begin
                if (settle_last) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Event counters restart whenever their state is not active.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            hold_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            if (state_q != S_OPEN) begin
                hold_cnt <= '0;
            end else if (second_pulse) begin
                hold_cnt <= hold_last ? '0 : hold_cnt + 1'b1;
            end

            if (state_q != S_CLOSE) begin
                settle_cnt <= '0;
            end else if (frame_wrap) begin
                settle_cnt <= settle_last ? '0 : settle_cnt + 1'b1;
            end
        end
    end

    // A request and a dequeue in the same cycle cancel out.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pending     <= '0;
            req_dropped <= 1'b0;
            dose_count  <= '0;
        end else begin
            req_dropped <= drop;
            case ({accept, dequeue})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
            if (done && (dose_count != 8'hFF)) begin
                dose_count <= dose_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_servo_dispense_driver.sv
// Self-checking bench for servo_dispense_driver: a queue of expected dose counts is
// filled as requests are driven and drained by a monitor on every done pulse.
module tb_servo_dispense_driver;

    localparam int PERIOD  = 100;
    localparam int W_CLOSE = 5;
    localparam int W_OPEN  = 10;
    localparam int SP_GAP  = 300;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       second_pulse = 1'b0;
    logic       enable = 1'b1;
    logic       dispense_req = 1'b0;
    logic       override_req = 1'b0;
    logic       servo_pwm;
    logic       busy;
    logic       done;
    logic       req_dropped;
    logic [2:0] pending;
    logic [7:0] dose_count;

    int n_checks  = 0;
    int n_errors  = 0;
    int done_seen = 0;
    int drop_seen = 0;
    int sp_cnt    = 0;
    int exp_e;
    int exp_q[$];

    servo_dispense_driver #(
        .PWM_PERIOD   (PERIOD),
        .PULSE_CLOSED (W_CLOSE),
        .PULSE_OPEN   (W_OPEN),
        .HOLD_SECONDS (2),
        .SETTLE_FRAMES(1),
        .MAX_PENDING  (3)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .second_pulse(second_pulse),
        .enable      (enable),
        .dispense_req(dispense_req),
        .override_req(override_req),
        .servo_pwm   (servo_pwm),
        .busy        (busy),
        .done        (done),
        .req_dropped (req_dropped),
        .pending     (pending),
        .dose_count  (dose_count)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // 1 Hz tick stand-in
    initial forever begin
        @(negedge clock);
        sp_cnt++;
        second_pulse = ((sp_cnt % SP_GAP) == 0);
    end

    // Scoreboard drain: each done pulse pops the dose count expected one cycle later.
    initial forever begin
        @(negedge clock);
        if (resetn && done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                exp_e = exp_q.pop_front();
                @(negedge clock);
                check("dose_count_after_done", int'(dose_count), exp_e);
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (resetn && req_dropped) drop_seen++;
    end

    initial begin
        #(50000 * 10);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        @(negedge clock);
        resetn       = 1'b0;
        dispense_req = 1'b0;
        override_req = 1'b0;
        @(negedge clock);
        exp_q.delete();
        resetn = 1'b1;
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_pwm"},        int'(servo_pwm),   0);
        check({pfx, "_busy"},       int'(busy),        0);
        check({pfx, "_done"},       int'(done),        0);
        check({pfx, "_dropped"},    int'(req_dropped), 0);
        check({pfx, "_pending"},    int'(pending),     0);
        check({pfx, "_dose_count"}, int'(dose_count),  0);
    endtask

    // Called at the first negedge after reset: pwm must be high for cycles 1..W_CLOSE.
    task automatic check_frame_after_reset(input string tag);
        int bad = 0;
        for (int k = 0; k < PERIOD; k++) begin
            if (servo_pwm !== ((k >= 1 && k <= W_CLOSE) ? 1'b1 : 1'b0)) bad++;
            @(negedge clock);
        end
        check(tag, bad, 0);
    endtask

    task automatic pulse(input logic d, input logic o);
        dispense_req = d;
        override_req = o;
        @(negedge clock);
        dispense_req = 1'b0;
        override_req = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int t = 0;
        while (busy !== 1'b1 && t < 5) begin
            @(negedge clock);
            t++;
        end
        check(tag, int'(busy), 1);
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int t = 0;
        while (done_seen < target && t < budget) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        @(negedge clock);
        check(tag, done_seen, target);
    endtask

    task automatic measure_pulse(output int w);
        int t;
        w = -1;
        t = 0;
        while (servo_pwm !== 1'b0 && t < 3 * PERIOD) begin @(negedge clock); t++; end
        t = 0;
        while (servo_pwm !== 1'b1 && t < 3 * PERIOD) begin @(negedge clock); t++; end
        if (servo_pwm !== 1'b1) return;
        w = 0;
        while (servo_pwm === 1'b1 && w < 3 * PERIOD) begin @(negedge clock); w++; end
    endtask

    initial begin
        int w;
        int hi;
        int d0;
        int drops0;
        int acc;
        int exp_pend[5] = '{1, 2, 3, 3, 3};

        // 1: reset and idle PWM
        apply_reset();
        check_idle_outputs("t1_reset");
        check_frame_after_reset("t1_first_frame");
        hi = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (servo_pwm === 1'b1) hi++;
            @(negedge clock);
        end
        check("t1_high_cycles_300", hi, 3 * W_CLOSE);
        measure_pulse(w);
        check("t1_idle_width", w, W_CLOSE);
        check("t1_busy", int'(busy), 0);
        check("t1_pending", int'(pending), 0);
        check("t1_dose_count", int'(dose_count), 0);

        // 2: single dose
        apply_reset();
        d0 = done_seen;
        exp_q.push_back(1);
        pulse(1'b1, 1'b0);
        check("t2_pending_queued", int'(pending), 1);
        check("t2_busy_early", int'(busy), 0);
        @(negedge clock);
        check("t2_busy_rise", int'(busy), 1);
        check("t2_pending_dequeued", int'(pending), 0);
        measure_pulse(w);
        measure_pulse(w);
        check("t2_open_width", w, W_OPEN);
        wait_done("t2_done_count", d0 + 1, 1000);
        measure_pulse(w);
        check("t2_closed_width_after", w, W_CLOSE);
        check("t2_busy_end", int'(busy), 0);
        check("t2_dose_count", int'(dose_count), 1);

        // 3: queue saturation and back-to-back doses
        apply_reset();
        d0 = done_seen;
        exp_q.push_back(1);
        pulse(1'b1, 1'b0);
        wait_busy("t3_busy");
        drops0 = drop_seen;
        acc = 1;
        for (int i = 0; i < 5; i++) begin
            repeat (9) @(negedge clock);
            pulse(1'b0, 1'b1);
            check($sformatf("t3_pending_%0d", i), int'(pending), exp_pend[i]);
            check($sformatf("t3_dropped_%0d", i), int'(req_dropped), (i >= 3) ? 1 : 0);
            if (i < 3) begin
                acc++;
                exp_q.push_back(acc);
            end
        end
        @(negedge clock);
        check("t3_drop_pulses", drop_seen - drops0, 2);
        wait_done("t3_done_count", d0 + 4, 3500);
        check("t3_dose_count", int'(dose_count), 4);
        check("t3_pending_end", int'(pending), 0);
        check("t3_busy_end", int'(busy), 0);

        // 4: simultaneous requests count once
        apply_reset();
        d0 = done_seen;
        exp_q.push_back(1);
        pulse(1'b1, 1'b1);
        check("t4_pending", int'(pending), 1);
        wait_done("t4_done_count", d0 + 1, 1000);
        repeat (800) @(negedge clock);
        check("t4_no_extra_done", done_seen - d0, 1);
        check("t4_dose_count", int'(dose_count), 1);

        // 5: enable gating
        apply_reset();
        d0 = done_seen;
        enable = 1'b0;
        pulse(1'b1, 1'b0);
        check("t5_disabled_pending", int'(pending), 0);
        @(negedge clock);
        check("t5_disabled_busy", int'(busy), 0);
        enable = 1'b1;
        exp_q.push_back(1);
        pulse(1'b1, 1'b0);
        wait_busy("t5_busy");
        enable = 1'b0;
        pulse(1'b0, 1'b1);
        check("t5_open_disabled_pending", int'(pending), 0);
        wait_done("t5_done_count", d0 + 1, 1000);
        repeat (800) @(negedge clock);
        check("t5_no_extra_done", done_seen - d0, 1);
        check("t5_dose_count", int'(dose_count), 1);
        enable = 1'b1;

        // 6: reset mid-dose with requests queued
        apply_reset();
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        pulse(1'b1, 1'b0);
        wait_busy("t6_busy");
        repeat (5) @(negedge clock);
        pulse(1'b1, 1'b0);
        repeat (5) @(negedge clock);
        pulse(1'b0, 1'b1);
        check("t6_pending_before", int'(pending), 2);
        check("t6_busy_before", int'(busy), 1);
        d0 = done_seen;
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        exp_q.delete();
        check_idle_outputs("t6_reset");
        check_frame_after_reset("t6_first_frame");
        repeat (700) @(negedge clock);
        check("t6_no_done", done_seen - d0, 0);
        check("t6_busy_after", int'(busy), 0);
        check("t6_pending_after", int'(pending), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
